// File: rtl/uart_pkg.sv
// Shared definitions for the UART baud generator: state encoding, divisor
// limits and the helpers used to derive the reset divisor from parameters.
package uart_pkg;

   localparam int UART_MIN_DIV_INT = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   // Fixed-point cycles per oversample tick, rounded to nearest, F fraction bits.
   function automatic logic [63:0] default_div(input logic [63:0] clk_khz,
                                               input logic [63:0] baud,
                                               input logic [63:0] oversample,
                                               input int          frac_w);
      logic [63:0] num;
      logic [63:0] den;
      num = (clk_khz * 64'd1000) << frac_w;
      den = baud * oversample;
      return (num + (den >> 1)) / den;
   endfunction

endpackage

// File: rtl/uart_frac_divider.sv
// Fractional period generator: a down-counter whose reload length carries the
// overflow of a fraction accumulator, giving an exact long-run average period.
module uart_frac_divider #(
   parameter int INT_W  = 16,
   parameter int FRAC_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [INT_W-1:0]  act_int,
   input  logic [FRAC_W-1:0] act_frac,
   input  logic              run,
   input  logic              start,
   output logic              os_tick
);

   logic [INT_W:0]  cnt;
   logic [FRAC_W-1:0] acc;
   logic [FRAC_W:0] sum;
   logic [INT_W:0]  period;
   logic            reload;

   assign sum    = {1'b0, acc} + {1'b0, act_frac};
   assign period = {1'b0, act_int} + {{INT_W{1'b0}}, sum[FRAC_W]};
   // The tick cycle is the cycle the counter sits at zero, so it doubles as the period start.
   assign reload = start | os_tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         acc     <= '0;
         os_tick <= 1'b0;
      end else if (!run) begin
         cnt     <= '0;
         acc     <= '0;
         os_tick <= 1'b0;
      end else if (reload) begin
         cnt     <= period - {{INT_W{1'b0}}, 1'b1};
         acc     <= sum[FRAC_W-1:0];
         os_tick <= 1'b0;
      end else begin
         cnt     <= cnt - {{INT_W{1'b0}}, 1'b1};
         os_tick <= (cnt == {{INT_W{1'b0}}, 1'b1});
      end
   end

endmodule

// File: rtl/uart_baud_gen.sv
// Runtime-programmable fractional baud generator: oversample and bit ticks,
// with divisor updates staged in a shadow and applied only at period boundaries.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_KHZ   = 40000,
   parameter int DEFAULT_BAUD   = 115200,
   parameter int OVERSAMPLE     = 16,
   parameter int DIV_INT_WIDTH  = 16,
   parameter int DIV_FRAC_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_enable,
   input  logic [DIV_INT_WIDTH-1:0]  i_div_int,
   input  logic [DIV_FRAC_WIDTH-1:0] i_div_frac,
   input  logic                      i_div_load,
   output logic                      o_div_ack,
   output logic                      o_div_err,
   output logic                      o_os_tick,
   output logic                      o_bit_tick,
   output state_t                    o_state
);

   localparam logic [63:0] DEF_DIV = default_div(64'(CLK_FREQ_KHZ), 64'(DEFAULT_BAUD),
                                                 64'(OVERSAMPLE), DIV_FRAC_WIDTH);
   localparam logic [DIV_INT_WIDTH-1:0]  DEF_INT  = DEF_DIV[DIV_FRAC_WIDTH +: DIV_INT_WIDTH];
   localparam logic [DIV_FRAC_WIDTH-1:0] DEF_FRAC = DEF_DIV[DIV_FRAC_WIDTH-1:0];
   localparam int BIT_CNT_W = (clog2(OVERSAMPLE) < 1) ? 1 : clog2(OVERSAMPLE);
   localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(OVERSAMPLE - 1);

   state_t state;
   state_t state_nxt;
   logic   run;
   logic   start;
   logic   idle;

   logic [DIV_INT_WIDTH-1:0]  act_int,  shd_int,  eff_int;
   logic [DIV_FRAC_WIDTH-1:0] act_frac, shd_frac, eff_frac;
   logic                      pending;
   logic                      load_ok;
   logic                      load_bad;
   logic                      reload;
   logic                      apply_run;
   logic [BIT_CNT_W-1:0]      bit_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_enable) state_nxt = START;
         START:   state_nxt = i_enable ? RUN : IDLE;
         RUN:     if (!i_enable) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      run   = i_enable & (state != IDLE);
      start = (state == START);
      idle  = (state == IDLE);
   end

   assign o_state = state;

   // Divisor handshake: i_div_load is a single-cycle strobe qualifying
   // i_div_int/i_div_frac; there is no back-pressure. Each accepted update
   // (or burst of updates overwriting the shadow) yields exactly one
   // o_div_ack pulse on the first cycle the new divisor is in effect;
   // a rejected update yields o_div_err the cycle after the strobe.
   assign load_ok   = i_div_load & (i_div_int >= DIV_INT_WIDTH'(UART_MIN_DIV_INT));
   assign load_bad  = i_div_load & (i_div_int <  DIV_INT_WIDTH'(UART_MIN_DIV_INT));
   assign reload    = run & (start | o_os_tick);
   assign apply_run = pending & reload;

   // The divider sees the shadow on the reloading cycle so the new period starts immediately.
   assign eff_int  = apply_run ? shd_int  : act_int;
   assign eff_frac = apply_run ? shd_frac : act_frac;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_int   <= DEF_INT;
         act_frac  <= DEF_FRAC;
         shd_int   <= DEF_INT;
         shd_frac  <= DEF_FRAC;
         pending   <= 1'b0;
         o_div_ack <= 1'b0;
         o_div_err <= 1'b0;
      end else begin
         o_div_ack <= 1'b0;
         o_div_err <= load_bad;
         if (idle) begin
            if (load_ok) begin
               act_int   <= i_div_int;
               act_frac  <= i_div_frac;
               shd_int   <= i_div_int;
               shd_frac  <= i_div_frac;
               pending   <= 1'b0;
               o_div_ack <= 1'b1;
            end else if (pending) begin
               act_int   <= shd_int;
               act_frac  <= shd_frac;
               pending   <= 1'b0;
               o_div_ack <= 1'b1;
            end
         end else begin
            if (apply_run) begin
               act_int   <= shd_int;
               act_frac  <= shd_frac;
               pending   <= 1'b0;
               o_div_ack <= 1'b1;
            end
            // A load coinciding with an apply stays pending for the next boundary.
            if (load_ok) begin
               shd_int  <= i_div_int;
               shd_frac <= i_div_frac;
               pending  <= 1'b1;
            end
         end
      end
   end

   uart_frac_divider #(
      .INT_W  (DIV_INT_WIDTH),
      .FRAC_W (DIV_FRAC_WIDTH)
   ) u_frac_divider (
      .clk      (clk),
      .rst_n    (rst_n),
      .act_int  (eff_int),
      .act_frac (eff_frac),
      .run      (run),
      .start    (start),
      .os_tick  (o_os_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         bit_cnt <= '0;
      else if (!run)      bit_cnt <= '0;
      else if (o_os_tick) bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
   end

   assign o_bit_tick = o_os_tick & (bit_cnt == BIT_LAST);

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: tick times are predicted from the
// cumulative-period rule k*int + floor(k*frac/2^F) and compared per tick.
module tb_uart_baud_gen;
   import uart_pkg::*;

   localparam int INT_W  = 16;
   localparam int FRAC_W = 4;
   localparam int OS     = 16;

   logic              clk;
   logic              rst_n;
   logic              i_enable;
   logic [INT_W-1:0]  i_div_int;
   logic [FRAC_W-1:0] i_div_frac;
   logic              i_div_load;
   logic              o_div_ack;
   logic              o_div_err;
   logic              o_os_tick;
   logic              o_bit_tick;
   state_t            o_state;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int os_times[$];
   int bit_times[$];
   int ack_times[$];
   int err_times[$];
   logic [31:0] exp_q[$];

   typedef struct {
      string name;
      int    di;
      int    df;
      int    n;
      int    exp_first;
      int    exp_last;
   } vec_t;
   vec_t vecs[8];

   uart_baud_gen #(
      .CLK_FREQ_KHZ   (40000),
      .DEFAULT_BAUD   (115200),
      .OVERSAMPLE     (OS),
      .DIV_INT_WIDTH  (INT_W),
      .DIV_FRAC_WIDTH (FRAC_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_enable   (i_enable),
      .i_div_int  (i_div_int),
      .i_div_frac (i_div_frac),
      .i_div_load (i_div_load),
      .o_div_ack  (o_div_ack),
      .o_div_err  (o_div_err),
      .o_os_tick  (o_os_tick),
      .o_bit_tick (o_bit_tick),
      .o_state    (o_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // event monitor, sampled on the inactive edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_os_tick)  os_times.push_back(cyc);
         if (o_bit_tick) bit_times.push_back(cyc);
         if (o_div_ack)  ack_times.push_back(cyc);
         if (o_div_err)  err_times.push_back(cyc);
      end
   end

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // driver tasks
   task automatic do_load(input int di, input int df);
      i_div_int  = INT_W'(di);
      i_div_frac = FRAC_W'(df);
      i_div_load = 1'b1;
      @(negedge clk);
      i_div_load = 1'b0;
   endtask

   task automatic wait_tick(input string name, output int t);
      int budget;
      budget = 2000;
      t = -1;
      while (budget > 0 && t < 0) begin
         @(negedge clk);
         budget--;
         if (o_os_tick) t = cyc;
      end
      if (t < 0) check({name, "_timeout"}, 0, 1);
   endtask

   // Enable at this negedge; the sampling edge is E0 and tick k lands at
   // E0 + k*int + floor(k*frac/2^F).
   task automatic enable_and_check(input string name, input int di, input int df, input int n,
                                   output int first_off, output int last_off);
      int e0;
      int budget;
      int got;
      int expv;
      i_enable = 1'b1;
      e0 = cyc + 1;
      os_times.delete();
      bit_times.delete();
      for (int k = 1; k <= n; k++) exp_q.push_back(32'(e0 + k * di + ((k * df) >> FRAC_W)));
      budget = n * (di + 2) + 100;
      while (os_times.size() < n && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (os_times.size() < n) check({name, "_tick_count"}, os_times.size(), n);
      first_off = (os_times.size() > 0) ? os_times[0] - e0 : -1;
      last_off  = (os_times.size() >= n) ? os_times[n-1] - e0 : -1;
      for (int k = 1; k <= n; k++) begin
         got = (os_times.size() > 0) ? os_times.pop_front() : -1;
         check({name, "_os_tick"}, got, int'(exp_q.pop_front()));
      end
      for (int j = 1; j <= n / OS; j++) begin
         expv = e0 + (j * OS) * di + ((j * OS * df) >> FRAC_W);
         got = (bit_times.size() > 0) ? bit_times.pop_front() : -1;
         check({name, "_bit_tick"}, got, expv);
      end
      check({name, "_bit_extra"}, bit_times.size(), 0);
   endtask

   task automatic run_cfg(input string name, input int di, input int df, input int n,
                          output int first_off, output int last_off);
      i_enable = 1'b0;
      repeat (3) @(negedge clk);
      do_load(di, df);
      check({name, "_idle_ack"}, int'(o_div_ack), 1);
      @(negedge clk);
      check({name, "_ack_pulse"}, int'(o_div_ack), 0);
      enable_and_check(name, di, df, n, first_off, last_off);
   endtask

   initial begin
      #2_000_000;
      n_err++;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int f, l, t0, t1, t2, t3, di, df, n;
      rst_n      = 1'b0;
      i_enable   = 1'b0;
      i_div_load = 1'b0;
      i_div_int  = '0;
      i_div_frac = '0;

      vecs[0] = '{"v_dflt",   21, 11, 16,   21,  347};
      vecs[1] = '{"v_4_0",     4,  0, 32,    4,  128};
      vecs[2] = '{"v_4_8",     4,  8, 16,    4,   72};
      vecs[3] = '{"v_10_0",   10,  0, 16,   10,  160};
      vecs[4] = '{"v_2_15",    2, 15, 16,    2,   47};
      vecs[5] = '{"v_2_0",     2,  0, 16,    2,   32};
      vecs[6] = '{"v_7_3",     7,  3, 20,    7,  143};
      vecs[7] = '{"v_1000_15", 1000, 15, 2, 1000, 2001};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_os_tick", int'(o_os_tick), 0);
      check("rst_bit_tick", int'(o_bit_tick), 0);
      check("rst_ack", int'(o_div_ack), 0);
      check("rst_err", int'(o_div_err), 0);
      check("rst_state", int'(o_state), int'(IDLE));

      // defaults straight out of reset
      enable_and_check("dflt_reset", 21, 11, 16, f, l);
      check("dflt_first", f, 21);
      check("dflt_total", l, 347);

      for (int i = 0; i < 8; i++) begin
         run_cfg(vecs[i].name, vecs[i].di, vecs[i].df, vecs[i].n, f, l);
         check({vecs[i].name, "_first"}, f, vecs[i].exp_first);
         check({vecs[i].name, "_last"}, l, vecs[i].exp_last);
      end

      // mid-period load: current period finishes, then the new one
      run_cfg("base10", 10, 0, 2, f, l);
      wait_tick("s3a", t0);
      repeat (3) @(negedge clk);
      ack_times.delete();
      do_load(5, 0);
      wait_tick("s3b", t1);
      check("midload_cur_period", t1 - t0, 10);
      @(negedge clk);
      check("midload_ack", int'(o_div_ack), 1);
      wait_tick("s3c", t2);
      check("midload_next_period", t2 - t1, 5);
      check("midload_ack_count", ack_times.size(), 1);

      // rejected load
      wait_tick("s4a", t0);
      repeat (2) @(negedge clk);
      ack_times.delete();
      err_times.delete();
      do_load(1, 0);
      check("err_pulse", int'(o_div_err), 1);
      @(negedge clk);
      check("err_one_cycle", int'(o_div_err), 0);
      wait_tick("s4b", t1);
      wait_tick("s4c", t2);
      check("err_period_a", t1 - t0, 5);
      check("err_period_b", t2 - t1, 5);
      check("err_no_ack", ack_times.size(), 0);
      check("err_count", err_times.size(), 1);

      // load on the tick cycle applies one period later
      wait_tick("s5a", t0);
      ack_times.delete();
      do_load(8, 0);
      check("tickload_no_early_ack", int'(o_div_ack), 0);
      wait_tick("s5b", t1);
      check("tickload_old_period", t1 - t0, 5);
      @(negedge clk);
      check("tickload_ack", int'(o_div_ack), 1);
      wait_tick("s5c", t2);
      check("tickload_new_period", t2 - t1, 8);
      check("tickload_ack_count", ack_times.size(), 1);

      // two loads while pending: last one wins, single ack
      wait_tick("s6a", t0);
      @(negedge clk);
      ack_times.delete();
      do_load(6, 0);
      do_load(3, 0);
      wait_tick("s6b", t1);
      check("dbl_cur_period", t1 - t0, 8);
      wait_tick("s6c", t2);
      check("dbl_new_period", t2 - t1, 3);
      wait_tick("s6d", t3);
      check("dbl_new_period2", t3 - t2, 3);
      check("dbl_ack_count", ack_times.size(), 1);

      // async reset with a load pending, asserted while a tick is high
      wait_tick("s7a", t0);
      do_load(12, 0);
      wait_tick("s7b", t1);
      check("rst_pre_tick", int'(o_os_tick), 1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_os_tick", int'(o_os_tick), 0);
      check("arst_bit_tick", int'(o_bit_tick), 0);
      check("arst_ack", int'(o_div_ack), 0);
      check("arst_state", int'(o_state), int'(IDLE));
      i_enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_ack", int'(o_div_ack), 0);
      enable_and_check("post_rst", 21, 11, 16, f, l);
      check("post_rst_total", l, 347);

      // one-cycle enable drop clears acc and bit counter
      for (int i = 0; i < 5; i++) wait_tick("s8", t0);
      repeat (2) @(negedge clk);
      i_enable = 1'b0;
      @(negedge clk);
      enable_and_check("en_drop", 21, 11, 16, f, l);
      check("en_drop_first", f, 21);
      check("en_drop_total", l, 347);

      // randomized divisors against the cumulative-period model
      for (int r = 0; r < 6; r++) begin
         di = $urandom_range(12, 2);
         df = $urandom_range(15, 0);
         n  = $urandom_range(40, 16);
         run_cfg("rand", di, df, n, f, l);
      end

      i_enable = 1'b0;
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Runtime-programmable fractional baud-rate generator for the UART receive and transmit paths.
- Produces an oversample tick at clk / (div_int + div_frac/2^DIV_FRAC_WIDTH).
- Produces a bit tick every OVERSAMPLE oversample ticks.
- Accepts glitch-free divisor updates through a load/ack handshake.
- Reset divisor is computed from parameters, so the block works out of reset with no software setup.

## Interface
- CLK_FREQ_KHZ, 40000, input clock frequency in kHz
- DEFAULT_BAUD, 115200, baud rate applied at reset
- OVERSAMPLE, 16, oversample ticks per bit; integer ≥ 2
- DIV_INT_WIDTH, 16, integer divisor width
- DIV_FRAC_WIDTH, 4, fractional divisor width (units of 1/2^F)
- clk  input  1  clock; one clock domain
- rst_n  input  1  asynchronous, active-low reset
- i_enable  input  1  run when high; when low, counters are held cleared
- i_div_int  input  DIV_INT_WIDTH  integer part of cycles per oversample tick
- i_div_frac  input  DIV_FRAC_WIDTH  fractional part of cycles per oversample tick
- i_div_load  input  1  single-cycle strobe; samples i_div_int and i_div_frac
- o_div_ack  output  1  one-cycle pulse on the cycle a new divisor takes effect
- o_div_err  output  1  one-cycle pulse, the cycle after a load with i_div_int < 2
- o_os_tick  output  1  oversample tick, one cycle wide
- o_bit_tick  output  1  bit tick, one cycle wide

## Operation
- Reset divisor: D = round(CLK_FREQ_KHZ·1000·2^F / (DEFAULT_BAUD·OVERSAMPLE)); div_int = D >> F, div_frac = D mod 2^F. Default parameters give 21, 11 (21.6875 cycles).
- Active divisor registers: act_int, act_frac. Shadow registers: shd_int, shd_frac, plus a pending flag.
- Period rule: at the start of each oversample period, sum = acc + act_frac (F+1 bits).
  - Period length P = act_int + sum[F].
  - acc ← sum[F-1:0].
  - acc = 0 after reset and whenever enable is low.
- Down-counter (DIV_INT_WIDTH+1 bits): loads P-1 at period start and decrements each cycle. o_os_tick is registered and asserts for one cycle when the counter reaches 0.
- Bit counter, 0..OVERSAMPLE-1: increments on each o_os_tick. o_bit_tick asserts with the o_os_tick on which the counter wraps from OVERSAMPLE-1 to 0.
- Load handling:
  - i_div_load with i_div_int ≥ 2: captured into the shadow and the pending flag is set.
  - i_div_load with i_div_int < 2: rejected. Shadow, pending flag and active divisor are unchanged; o_div_err pulses.
  - A second valid load while pending overwrites the shadow. Only one ack is issued.
- Apply point:
  - Running: the pending shadow is copied to the active divisor at the next period start (the cycle after o_os_tick). The current period is never truncated. o_div_ack pulses that cycle.
  - Disabled: the shadow is applied on the cycle after the load, with o_div_ack on that cycle.
- States:
  - IDLE (i_enable low): counters and acc cleared, ticks low.
  - START (1 cycle): load the first period.
  - RUN: i_enable low → IDLE on the next edge, whatever the counter value. No tick is issued on that edge.

## Timing
- Reset values: all outputs 0, acc 0, bit counter 0, pending 0, active and shadow divisors set to the defaults.
- Enable sampled high at edge E0 → START at E0. The first o_os_tick is high after edge E0+P; the first period always has P = act_int + (act_frac ≥ 2^F ? 1 : 0) = act_int.
- Consecutive o_os_tick pulses are exactly P cycles apart.
- Long-run average period is exactly act_int + act_frac/2^F.
- Load and tick on the same cycle: the load is captured, and the apply happens at the period start after the *next* tick. The ack is never lost.
- Reset mid-operation: all state returns to the reset values on the asserting edge, asynchronously. Pending loads are discarded.
- Divisor widths: act_int max 2^DIV_INT_WIDTH−1. P max 2^DIV_INT_WIDTH.

## Structure
- Shared package uart_pkg:
  - clog2 function
  - default-divisor computation function
  - UART_MIN_DIV_INT = 2
  - state enum (IDLE, START, RUN)
- One sub-module: uart_frac_divider. It holds the down-counter and accumulator; its inputs are act_int, act_frac, run and start, and its output is the os tick.
- The top level owns the shadow and handshake logic, the state machine and the bit counter.

## Test plan
- Default reset, enable high: over 16 os ticks the total cycle count is 347 (11 periods of 22, 5 of 21). o_bit_tick pulses once, coincident with the 16th os tick.
- Disabled, load int 4 / frac 0: ack 1 cycle after the load. Then enable: os ticks every 4 cycles and a bit tick every 64 cycles.
- Load int 4 / frac 8: periods alternate 4, 5, 4, 5, starting with 4.
- While running with int 10, load int 5 mid-period: the current period completes at 10 cycles; ack is issued the cycle after that tick; the next period is 5 cycles.
- Load int 1 while running: o_div_err pulses; periods are unchanged; no ack.
- rst_n low mid-period: outputs 0 immediately. After release plus enable, the tick pattern restarts from the reset defaults. i_enable dropped for 1 cycle: the bit counter and acc are cleared.
